// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared BTB entry type, counter constants and saturating counter helper.
// Entry tag/target fields are sized to the widest supported PC (PC_SIZE).
// Narrower PC_W configurations zero-extend into them.
package branch_predictor_pkg;
    localparam int PC_SIZE = 16;
    localparam logic [1:0] CTR_RESET     = 2'b01;
    localparam logic [1:0] CTR_ALLOC_BR  = 2'b10;
    localparam logic [1:0] CTR_ALLOC_JMP = 2'b11;

    typedef struct packed {
        logic               valid;
        logic [PC_SIZE-1:0] tag;
        logic [PC_SIZE-1:0] target;
        logic [1:0]         ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_ctr_update(input logic [1:0] ctr, input logic taken);
        return taken ? ((ctr == 2'b11) ? ctr : ctr + 2'b01)
                     : ((ctr == 2'b00) ? ctr : ctr - 2'b01);
    endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, decode feedback and redirect signals of the branch predictor.
// master = fetch/decode side (drives i_*), slave = predictor (drives o_*).
interface branch_predictor_if #(parameter int PC_W = branch_predictor_pkg::PC_SIZE);
    logic [PC_W-1:0] i_fetch_pc;
    logic            o_pred_taken;
    logic [PC_W-1:0] o_pred_target;
    logic            i_fb_valid;
    logic            i_fb_branch;
    logic [PC_W-1:0] i_fb_pc;
    logic [PC_W-1:0] i_fb_predict_target;
    logic [PC_W-1:0] i_fb_feedback_target;
    logic            i_fb_predict_taken;
    logic            i_fb_feedback_taken;
    logic            o_redirect;
    logic [PC_W-1:0] o_redirect_pc;
    logic [15:0]     o_mispredict_count;

    modport master (
        output i_fetch_pc, i_fb_valid, i_fb_branch, i_fb_pc, i_fb_predict_target,
               i_fb_feedback_target, i_fb_predict_taken, i_fb_feedback_taken,
        input  o_pred_taken, o_pred_target, o_redirect, o_redirect_pc, o_mispredict_count
    );
    modport slave (
        input  i_fetch_pc, i_fb_valid, i_fb_branch, i_fb_pc, i_fb_predict_target,
               i_fb_feedback_target, i_fb_predict_taken, i_fb_feedback_taken,
        output o_pred_taken, o_pred_target, o_redirect, o_redirect_pc, o_mispredict_count
    );
endinterface

// File: rtl/branch_predictor_resolve.sv
// branch_resolve: combinational resolution of one decode feedback record.
// Ports: fb_*_i feedback record in; actual_taken_o resolved direction,
// mispredict_o prediction was wrong, redirect_pc_o correct next PC (0 when invalid).
module branch_resolve #(
    parameter int PC_W = 16
) (
    input  logic            fb_valid_i,
    input  logic            fb_branch_i,
    input  logic [PC_W-1:0] fb_pc_i,
    input  logic [PC_W-1:0] fb_predict_target_i,
    input  logic [PC_W-1:0] fb_feedback_target_i,
    input  logic            fb_predict_taken_i,
    input  logic            fb_feedback_taken_i,
    output logic            actual_taken_o,
    output logic            mispredict_o,
    output logic [PC_W-1:0] redirect_pc_o
);
    // Jumps are always taken regardless of the feedback direction bit.
    assign actual_taken_o = fb_branch_i ? fb_feedback_taken_i : 1'b1;
    assign mispredict_o   = fb_valid_i && ((actual_taken_o != fb_predict_taken_i) ||
                            (actual_taken_o && fb_predict_target_i != fb_feedback_target_i));
    assign redirect_pc_o  = !fb_valid_i ? '0 :
                            actual_taken_o ? fb_feedback_target_i : fb_pc_i + PC_W'(1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters, trained from decode feedback.
// Ports: clk, rst (sync, active-high); bp slave modport carries fetch lookup
// (i_fetch_pc -> o_pred_taken/o_pred_target), feedback record (i_fb_*),
// redirect (o_redirect/o_redirect_pc) and the saturating o_mispredict_count.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int  PC_W    = PC_SIZE,
    parameter int  ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predictor_if.slave    bp
);
    btb_entry_t       btb_q [ENTRIES];
    btb_entry_t       f_e;
    btb_entry_t       u_e;
    btb_entry_t       upd_d;
    logic             upd_we;
    logic             f_hit;
    logic             u_hit;
    logic [IDX_W-1:0] u_idx;
    logic             actual_taken;
    logic             mispredict;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;

    branch_resolve #(.PC_W(PC_W)) u_resolve (
        .fb_valid_i          (bp.i_fb_valid),
        .fb_branch_i         (bp.i_fb_branch),
        .fb_pc_i             (bp.i_fb_pc),
        .fb_predict_target_i (bp.i_fb_predict_target),
        .fb_feedback_target_i(bp.i_fb_feedback_target),
        .fb_predict_taken_i  (bp.i_fb_predict_taken),
        .fb_feedback_taken_i (bp.i_fb_feedback_taken),
        .actual_taken_o      (actual_taken),
        .mispredict_o        (mispredict),
        .redirect_pc_o       (bp.o_redirect_pc)
    );

    // Lookup reads the registered table only: an update in the same cycle is not bypassed.
    assign f_e              = btb_q[bp.i_fetch_pc[IDX_W-1:0]];
    assign f_hit            = f_e.valid && f_e.tag == PC_SIZE'(bp.i_fetch_pc >> IDX_W);
    assign bp.o_pred_taken  = !rst && f_hit && f_e.ctr[1];
    assign bp.o_pred_target = bp.o_pred_taken ? f_e.target[PC_W-1:0] : bp.i_fetch_pc + PC_W'(1);

    assign bp.o_redirect         = !rst && mispredict;
    assign bp.o_mispredict_count = cnt_q;

    assign u_idx = bp.i_fb_pc[IDX_W-1:0];
    assign u_e   = btb_q[u_idx];
    assign u_hit = u_e.valid && u_e.tag == PC_SIZE'(bp.i_fb_pc >> IDX_W);

    // Hits train the counter (and the target when taken); taken misses evict the occupant.
    always_comb begin
        upd_d  = u_e;
        upd_we = 1'b0;
        if (bp.i_fb_valid && u_hit) begin
            upd_we    = 1'b1;
            upd_d.ctr = sat_ctr_update(u_e.ctr, actual_taken);
            if (actual_taken) upd_d.target = PC_SIZE'(bp.i_fb_feedback_target);
        end else if (bp.i_fb_valid && actual_taken) begin
            upd_we       = 1'b1;
            upd_d.valid  = 1'b1;
            upd_d.tag    = PC_SIZE'(bp.i_fb_pc >> IDX_W);
            upd_d.target = PC_SIZE'(bp.i_fb_feedback_target);
            upd_d.ctr    = bp.i_fb_branch ? CTR_ALLOC_BR : CTR_ALLOC_JMP;
        end
    end

    assign cnt_d = (mispredict && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            cnt_q <= '0;
        end else begin
            if (upd_we) btb_q[u_idx] <= upd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and randomized checks of branch_predictor against a behavioural model.
module tb_branch_predictor;
    localparam int PC_W = 16;
    localparam int N    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if #(.PC_W(PC_W)) bp ();
    branch_predictor #(.PC_W(PC_W), .ENTRIES(N)) dut (.clk(clk), .rst(rst), .bp(bp));

    bit m_v   [N];
    int m_tag [N];
    int m_tgt [N];
    int m_ctr [N];
    int m_cnt;
    int n_chk;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input int pc);
        return m_v[pc % N] && m_tag[pc % N] == pc / N;
    endfunction

    function automatic bit m_ptaken(input int pc);
        return m_hit(pc) && m_ctr[pc % N] >= 2;
    endfunction

    function automatic int m_ptarget(input int pc);
        return m_ptaken(pc) ? m_tgt[pc % N] : (pc + 1) % 65536;
    endfunction

    function automatic bit m_actual();
        return bp.i_fb_branch ? bp.i_fb_feedback_taken : 1'b1;
    endfunction

    function automatic bit m_misp();
        bit a;
        a = m_actual();
        return bp.i_fb_valid && (a != bp.i_fb_predict_taken ||
               (a && bp.i_fb_predict_target != bp.i_fb_feedback_target));
    endfunction

    task automatic drive(input bit v, input bit br, input int pc, input bit pt,
                         input int ptg, input int ftg, input bit ft);
        bp.i_fb_valid           = v;
        bp.i_fb_branch          = br;
        bp.i_fb_pc              = PC_W'(pc);
        bp.i_fb_predict_taken   = pt;
        bp.i_fb_predict_target  = PC_W'(ptg);
        bp.i_fb_feedback_target = PC_W'(ftg);
        bp.i_fb_feedback_taken  = ft;
    endtask

    task automatic settle(input bit chk);
        int pc;
        int rpc;
        #4;
        pc  = int'(bp.i_fetch_pc);
        rpc = !bp.i_fb_valid ? 0 : m_actual() ? int'(bp.i_fb_feedback_target) : (int'(bp.i_fb_pc) + 1) % 65536;
        if (chk) begin
            check("pred_taken", 32'(bp.o_pred_taken), 32'(!rst && m_ptaken(pc)));
            check("pred_target", 32'(bp.o_pred_target), 32'(rst ? (pc + 1) % 65536 : m_ptarget(pc)));
            check("redirect", 32'(bp.o_redirect), 32'(!rst && m_misp()));
            check("redirect_pc", 32'(bp.o_redirect_pc), 32'(rpc));
            check("count", 32'(bp.o_mispredict_count), 32'(m_cnt));
        end
    endtask

    task automatic tick();
        int idx;
        bit a;
        @(posedge clk);
        a   = m_actual();
        idx = int'(bp.i_fb_pc) % N;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_v[i]   = 1'b0;
                m_ctr[i] = 1;
            end
            m_cnt = 0;
        end else if (bp.i_fb_valid) begin
            if (m_misp() && m_cnt < 65535) m_cnt++;
            if (m_hit(int'(bp.i_fb_pc))) begin
                m_ctr[idx] = a ? (m_ctr[idx] < 3 ? m_ctr[idx] + 1 : 3) : (m_ctr[idx] > 0 ? m_ctr[idx] - 1 : 0);
                if (a) m_tgt[idx] = int'(bp.i_fb_feedback_target);
            end else if (a) begin
                m_v[idx]   = 1'b1;
                m_tag[idx] = int'(bp.i_fb_pc) / N;
                m_tgt[idx] = int'(bp.i_fb_feedback_target);
                m_ctr[idx] = bp.i_fb_branch ? 2 : 3;
            end
        end
        #1;
    endtask

    task automatic step(input bit chk);
        settle(chk);
        tick();
    endtask

    initial begin
        int pc;
        int ftg;
        n_chk = 0;
        n_fail = 0;
        m_cnt = 0;
        rst = 1'b1;
        bp.i_fetch_pc = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        step(0);
        step(0);
        rst = 1'b0;

        bp.i_fetch_pc = 16'h0010;
        settle(1);
        check("rst_pred_taken", 32'(bp.o_pred_taken), 0);
        check("rst_pred_target", 32'(bp.o_pred_target), 32'h0011);
        check("rst_count", 32'(bp.o_mispredict_count), 0);
        tick();

        drive(1, 0, 16'h0014, 0, 16'h0015, 16'h0100, 0);
        bp.i_fetch_pc = 16'h0014;
        settle(1);
        check("jmp_redirect", 32'(bp.o_redirect), 1);
        check("jmp_redirect_pc", 32'(bp.o_redirect_pc), 32'h0100);
        check("jmp_no_bypass", 32'(bp.o_pred_taken), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        settle(1);
        check("jmp_pred_taken", 32'(bp.o_pred_taken), 1);
        check("jmp_pred_target", 32'(bp.o_pred_target), 32'h0100);
        check("jmp_count", 32'(bp.o_mispredict_count), 1);
        tick();

        bp.i_fetch_pc = 16'h0025;
        drive(1, 1, 16'h0025, 0, 16'h0026, 16'h0080, 1);
        step(1);
        drive(1, 1, 16'h0025, 1, 16'h0080, 16'h0080, 0);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0);
        settle(1);
        check("hyst_ctr1", 32'(bp.o_pred_taken), 0);
        tick();
        drive(1, 1, 16'h0025, 0, 16'h0026, 16'h0080, 0);
        step(1);
        drive(1, 1, 16'h0025, 0, 16'h0026, 16'h0080, 1);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0);
        settle(1);
        check("hyst_ctr0_up", 32'(bp.o_pred_taken), 0);
        tick();

        drive(1, 0, 16'h0003, 0, 0, 16'h0200, 0);
        step(1);
        drive(1, 0, 16'h0013, 0, 0, 16'h0300, 0);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0);
        bp.i_fetch_pc = 16'h0003;
        settle(1);
        check("alias_evicted", 32'(bp.o_pred_taken), 0);
        check("alias_evicted_tgt", 32'(bp.o_pred_target), 32'h0004);
        tick();
        bp.i_fetch_pc = 16'h0013;
        settle(1);
        check("alias_new_tgt", 32'(bp.o_pred_target), 32'h0300);
        tick();

        bp.i_fetch_pc = 16'hFFFF;
        settle(1);
        check("wrap_target", 32'(bp.o_pred_target), 0);
        tick();

        for (int k = 0; k < 600; k++) begin
            pc  = $urandom_range(0, 47);
            ftg = ($urandom_range(0, 3) == 0) ? (pc + 1) : 32'($urandom_range(1, 3)) * 256;
            if ($urandom_range(0, 9) < 7)
                drive(1, 1'($urandom), pc, m_ptaken(pc), m_ptarget(pc), ftg, 1'($urandom));
            else
                drive(1'($urandom), 1'($urandom), pc, 1'($urandom), 32'($urandom_range(1, 3)) * 256, ftg, 1'($urandom));
            bp.i_fetch_pc = ($urandom_range(0, 3) == 0) ? PC_W'(pc) : PC_W'($urandom_range(0, 47));
            step(1);
        end

        drive(1, 0, 16'h0030, 0, 0, 16'h0555, 0);
        for (int k = 0; k < 65540; k++) step(0);
        settle(1);
        check("count_saturated", 32'(bp.o_mispredict_count), 32'hFFFF);
        tick();

        rst = 1'b1;
        drive(1, 0, 16'h0040, 0, 0, 16'h0123, 0);
        bp.i_fetch_pc = 16'h0040;
        settle(1);
        check("rst_fb_redirect", 32'(bp.o_redirect), 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        settle(1);
        check("rst_fb_no_write", 32'(bp.o_pred_taken), 0);
        check("rst_fb_target", 32'(bp.o_pred_target), 32'h0041);
        check("rst_fb_count", 32'(bp.o_mispredict_count), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Sits beside fetch. Each cycle it supplies a next-PC prediction for the fetch PC, using a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- It consumes the branch feedback record that decode produces (valid, branch, pc, predict/feedback target, predict/feedback taken).
- It trains the tables from that feedback and raises a same-cycle redirect on mispredict.

Parameters:
- PC_W, `PC_SIZE, PC width in bits.
- ENTRIES, 16, number of BTB entries; must be a power of 2, minimum 2.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_fetch_pc  in  PC_W  PC currently being fetched.
- o_pred_taken  out  1  prediction that i_fetch_pc is a taken branch/jump.
- o_pred_target  out  PC_W  predicted next PC.
- i_fb_valid  in  1  feedback record valid (branch_feedback_ifc.valid).
- i_fb_branch  in  1  1 = conditional branch, 0 = jump.
- i_fb_pc  in  PC_W  PC of the resolved instruction.
- i_fb_predict_target  in  PC_W  target that was predicted for it.
- i_fb_feedback_target  in  PC_W  resolved target.
- i_fb_predict_taken  in  1  direction that was predicted.
- i_fb_feedback_taken  in  1  resolved direction (ps); ignored for jumps.
- o_redirect  out  1  mispredict; fetch must flush and load o_redirect_pc.
- o_redirect_pc  out  PC_W  correct next PC.
- o_mispredict_count  out  16  saturating mispredict counter.

Behaviour:
- Entry fields: valid, tag (PC_W-IDX_W bits), target (PC_W), ctr (2 bits).
  - Index = pc[IDX_W-1:0].
  - Tag = pc[PC_W-1:IDX_W].
- Reset (rst=1 at clk edge):
  - All valid bits cleared, all ctr set to 2'b01 (weak not-taken).
  - o_mispredict_count set to 0.
  - rst takes priority over any simultaneous feedback write.
  - While rst is high, o_redirect is forced to 0 and o_pred_taken to 0.
- Lookup (combinational, zero latency) on i_fetch_pc:
  - Hit = entry valid and tag match.
  - o_pred_taken = hit & ctr[1].
  - o_pred_target = o_pred_taken ? entry.target : i_fetch_pc + 1, wrapping modulo 2^PC_W.
- Resolution (combinational from feedback):
  - actual_taken = i_fb_branch ? i_fb_feedback_taken : 1.
  - mispredict = i_fb_valid & ((actual_taken != i_fb_predict_taken) | (actual_taken & i_fb_predict_target != i_fb_feedback_target)).
  - o_redirect = mispredict.
  - o_redirect_pc = actual_taken ? i_fb_feedback_target : i_fb_pc + 1 (wrapping).
  - When i_fb_valid=0: o_redirect=0 and o_redirect_pc=0.
- Update (registered; visible to lookups from the next cycle) when i_fb_valid=1, at index of i_fb_pc:
  - Entry hit (valid and tag match): ctr increments (saturate at 3) if actual_taken, else decrements (saturate at 0). If actual_taken, target <= i_fb_feedback_target.
  - Entry miss and actual_taken: allocate, overwriting any occupant. valid=1, tag, target, and ctr = 3 for a jump or 2 for a branch.
  - Entry miss and not taken: no write.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents; no bypass.
- o_mispredict_count increments by 1 on each mispredict cycle and holds at 16'hFFFF.
- Tables are flops; no memory macros.

Decomposition:
- Shared package (nand_cpu pkg / nand_cpu.svh) holds:
  - typedef btb_entry_t {valid, tag, target, ctr}.
  - localparams for counter reset value (2'b01) and allocation values (2'b10, 2'b11).
  - function sat_ctr_update(ctr, taken).
- One sub-module, branch_resolve: purely combinational; computes actual_taken, mispredict and redirect_pc from the feedback record. branch_predictor instantiates it and owns the tables and counter.

Test Plan:
- Reset check: rst high for 2 cycles, then fetch pc=0x0010 -> o_pred_taken=0, o_pred_target=0x0011, o_mispredict_count=0.
- Jump train: feedback {valid, branch=0, pc=0x0014, predict_taken=0, feedback_target=0x0100} -> same-cycle o_redirect=1, o_redirect_pc=0x0100, count=1. Next cycle fetch 0x0014 -> pred_taken=1, target=0x0100.
- Branch hysteresis:
  - Allocate branch pc=0x0025 taken (ctr=2), then two not-taken feedbacks with predict_taken matching the prediction.
  - After the first not-taken, fetch 0x0025 -> not taken (ctr=1).
  - After the second, ctr=0. Then one taken feedback -> still predicts not taken (ctr=1).
- Alias eviction (ENTRIES=16): train jump pc=0x0003 to 0x0200, then jump pc=0x0013 to 0x0300. Fetch 0x0003 -> miss, target 0x0004. Fetch 0x0013 -> 0x0300.
- Wrap and saturation:
  - Fetch 0xFFFF with no entry -> o_pred_target=0x0000.
  - Force 65540 mispredicts -> count holds at 0xFFFF.
- Simultaneous update and reset: feedback valid with rst=1 -> no table write, o_redirect=0. After release, fetch of that pc misses.
